// File: rtl/temp_report_seq.sv
// Formats a signed 8-bit temperature as an ASCII frame (sign, three digits,
// unit, line end) and hands it byte by byte to a UART transmitter.
module temp_report_seq #(
  parameter logic [7:0] UNIT_CHAR = 8'h43,
  parameter bit         EOL_CRLF  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       temp_valid,
  input  logic [7:0] temp_value,
  input  logic       tx_done_tick,
  output logic [7:0] data_byte,
  output logic       tx_start,
  output logic       busy,
  output logic       frame_done_tick,
  output logic       drop_tick
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    SEND = 2'd2,
    WAIT = 2'd3
  } state_t;

  localparam logic [2:0] LAST_IDX = EOL_CRLF ? 3'd6 : 3'd5;

  state_t      r_state;
  logic        r_sign;
  logic [8:0]  r_rem;
  logic [3:0]  r_hund;
  logic [3:0]  r_tens;
  logic [3:0]  r_units;
  logic [2:0]  r_idx;
  logic [7:0]  r_data;
  logic        r_tx_start;
  logic        r_busy;

  logic [8:0]  w_mag;
  logic        w_last;

  function automatic logic [7:0] frame_byte(
    input logic [2:0] idx,
    input logic       sign,
    input logic [3:0] hund,
    input logic [3:0] tens,
    input logic [3:0] units
  );
    case (idx)
      3'd0:    frame_byte = sign ? 8'h2D : 8'h2B;
      3'd1:    frame_byte = 8'h30 + {4'd0, hund};
      3'd2:    frame_byte = 8'h30 + {4'd0, tens};
      3'd3:    frame_byte = 8'h30 + {4'd0, units};
      3'd4:    frame_byte = UNIT_CHAR;
      3'd5:    frame_byte = EOL_CRLF ? 8'h0D : 8'h0A;
      default: frame_byte = 8'h0A;
    endcase
  endfunction

  // 9-bit magnitude so that -128 becomes +128 rather than wrapping.
  assign w_mag  = temp_value[7] ? (9'd0 - {1'b1, temp_value}) : {1'b0, temp_value};
  assign w_last = (r_idx == LAST_IDX);

  // The frame-end and drop strobes must land in the cycle of the triggering input.
  assign frame_done_tick = (r_state == WAIT) && tx_done_tick && w_last;
  assign drop_tick       = temp_valid && (r_state != IDLE);

  assign data_byte = r_data;
  assign tx_start  = r_tx_start;
  assign busy      = r_busy;

  // Capture, BCD conversion by repeated subtraction, and byte hand-off.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_sign     <= 1'b0;
      r_rem      <= 9'd0;
      r_hund     <= 4'd0;
      r_tens     <= 4'd0;
      r_units    <= 4'd0;
      r_idx      <= 3'd0;
      r_data     <= 8'hFF;
      r_tx_start <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx_start <= 1'b1;
          if (temp_valid) begin
            r_sign  <= temp_value[7];
            r_rem   <= w_mag;
            r_hund  <= 4'd0;
            r_tens  <= 4'd0;
            r_units <= 4'd0;
            r_idx   <= 3'd0;
            r_busy  <= 1'b1;
            r_state <= CONV;
          end
        end
        CONV: begin
          if (r_rem >= 9'd100) begin
            r_rem  <= r_rem - 9'd100;
            r_hund <= r_hund + 4'd1;
          end else if (r_rem >= 9'd10) begin
            r_rem  <= r_rem - 9'd10;
            r_tens <= r_tens + 4'd1;
          end else begin
            r_units    <= r_rem[3:0];
            r_data     <= frame_byte(3'd0, r_sign, r_hund, r_tens, r_units);
            r_tx_start <= 1'b0;
            r_state    <= SEND;
          end
        end
        SEND: begin
          r_tx_start <= 1'b1;
          r_state    <= WAIT;
        end
        WAIT: begin
          // data_byte is held here: the transmitter may still be sampling it.
          if (tx_done_tick) begin
            if (w_last) begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_idx      <= r_idx + 3'd1;
              r_data     <= frame_byte(r_idx + 3'd1, r_sign, r_hund, r_tens, r_units);
              r_tx_start <= 1'b0;
              r_state    <= SEND;
            end
          end
        end
        default: begin
          r_tx_start <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_temp_report_seq.sv
// Bench for temp_report_seq: frame-level model plus directed frames with
// literal byte expectations; a second instance covers the LF-only line end.
module tb_temp_report_seq;

  logic       clk;
  logic       reset_n;
  logic       temp_valid;
  logic [7:0] temp_value;
  logic       tx_done_tick;
  logic [7:0] data_byte;
  logic       tx_start;
  logic       busy;
  logic       frame_done_tick;
  logic       drop_tick;

  logic       lf_valid;
  logic [7:0] lf_value;
  logic       lf_done;
  logic [7:0] lf_data;
  logic       lf_start;
  logic       lf_busy;
  logic       lf_fd;
  logic       lf_drop;

  int n_vec = 0;
  int n_err = 0;

  temp_report_seq dut (
    .clk(clk), .reset(reset_n), .temp_valid(temp_valid), .temp_value(temp_value),
    .tx_done_tick(tx_done_tick), .data_byte(data_byte), .tx_start(tx_start),
    .busy(busy), .frame_done_tick(frame_done_tick), .drop_tick(drop_tick)
  );

  temp_report_seq #(.UNIT_CHAR(8'h43), .EOL_CRLF(1'b0)) dut_lf (
    .clk(clk), .reset(reset_n), .temp_valid(lf_valid), .temp_value(lf_value),
    .tx_done_tick(lf_done), .data_byte(lf_data), .tx_start(lf_start),
    .busy(lf_busy), .frame_done_tick(lf_fd), .drop_tick(lf_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model of the main instance
  logic [7:0] m_exp[$];
  int         m_sent;
  int         m_start_in;
  int         m_conv;
  logic       m_busy;
  logic       m_out;
  logic [7:0] m_held;

  function automatic void build_frame(input int v);
    int mag;
    mag = (v < 0) ? -v : v;
    m_exp.delete();
    m_exp.push_back((v < 0) ? 8'h2D : 8'h2B);
    m_exp.push_back(8'(48 + mag / 100));
    m_exp.push_back(8'(48 + (mag % 100) / 10));
    m_exp.push_back(8'(48 + mag % 10));
    m_exp.push_back(8'h43);
    m_exp.push_back(8'h0D);
    m_exp.push_back(8'h0A);
    m_conv = mag / 100 + (mag % 100) / 10 + 1;
  endfunction

  always @(negedge clk) begin
    logic exp_low;
    logic done_ok;
    logic busy_n;
    if (!reset_n) begin
      chk1("rst_tx_start", tx_start, 1'b1);
      chk8("rst_data_byte", data_byte, 8'hFF);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_frame_done", frame_done_tick, 1'b0);
      chk1("rst_drop", drop_tick, 1'b0);
      m_busy     = 1'b0;
      m_out      = 1'b0;
      m_sent     = 0;
      m_start_in = -1;
    end else begin
      exp_low = (m_start_in == 0);
      done_ok = tx_done_tick && m_out;
      busy_n  = m_busy;
      chk1("busy", busy, m_busy);
      chk1("drop_tick", drop_tick, temp_valid && m_busy);
      chk1("tx_start", tx_start, !exp_low);
      chk1("frame_done", frame_done_tick, done_ok && (m_sent == 7));
      if (exp_low) begin
        if (m_sent < m_exp.size()) chk8("model_byte", data_byte, m_exp[m_sent]);
        m_held = data_byte;
        m_out  = 1'b1;
        m_sent++;
      end else if (m_out) begin
        chk8("data_hold", data_byte, m_held);
      end
      if (m_start_in >= 0) m_start_in--;
      if (done_ok) begin
        m_out = 1'b0;
        if (m_sent == 7) busy_n = 1'b0;
        else             m_start_in = 0;
      end
      if (temp_valid && !m_busy) begin
        build_frame(int'($signed(temp_value)));
        m_sent     = 0;
        m_start_in = m_conv;
        busy_n     = 1'b1;
      end
      m_busy = busy_n;
    end
  end

  // Drives one frame through either instance acting as the UART transmitter.
  // mode: 0 plain, 1 stray request in WAIT of byte 3, 2 request coincident with
  // frame end, 3 reset during WAIT of byte 2.
  task automatic do_frame(input bit lf, input logic [7:0] v, input int nbytes,
                          input logic [55:0] exp, input int dly, input int mode,
                          input bit pre);
    logic found;
    logic [7:0] got;
    if (!pre) begin
      @(posedge clk); #1;
      if (lf) begin lf_valid = 1'b1; lf_value = v; end
      else    begin temp_valid = 1'b1; temp_value = v; end
    end
    @(posedge clk); #1;
    lf_valid   = 1'b0;
    temp_valid = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
        @(negedge clk);
        found = lf ? !lf_start : !tx_start;
      end
      if (!found) begin
        n_vec++; n_err++;
        $display("FAIL start_timeout: no tx_start for byte %0d, required within 40 cycles", i);
        return;
      end
      got = lf ? lf_data : data_byte;
      chk8("frame_byte", got, exp[55 - 8*i -: 8]);
      if (mode == 3 && i == 1) begin
        @(posedge clk); #1 reset_n = 1'b0;
        @(negedge clk);
        chk1("abort_tx_start", tx_start, 1'b1);
        chk1("abort_busy", busy, 1'b0);
        chk8("abort_data", data_byte, 8'hFF);
        return;
      end
      repeat (dly) @(posedge clk);
      #1;
      if (mode == 1 && i == 2) begin
        temp_valid = 1'b1; temp_value = 8'd50;
        @(negedge clk);
        chk1("drop_in_wait", drop_tick, 1'b1);
        @(posedge clk); #1 temp_valid = 1'b0;
      end
      if (mode == 2 && i == nbytes - 1) begin
        temp_valid = 1'b1; temp_value = 8'd50;
      end
      if (lf) lf_done = 1'b1; else tx_done_tick = 1'b1;
      @(negedge clk);
      chk1("frame_done_at_done", lf ? lf_fd : frame_done_tick, i == nbytes - 1);
      if (mode == 2 && i == nbytes - 1) chk1("drop_at_frame_done", drop_tick, 1'b1);
      @(posedge clk); #1;
      lf_done      = 1'b0;
      tx_done_tick = 1'b0;
      temp_valid   = 1'b0;
    end
    @(negedge clk);
    chk1("busy_after_frame", lf ? lf_busy : busy, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; temp_valid = 1'b0; temp_value = 8'd0; tx_done_tick = 1'b0;
    lf_valid = 1'b0; lf_value = 8'd0; lf_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    do_frame(1'b0, 8'd25,  7, 56'h2B303235430D0A, 1, 0, 1'b0);
    do_frame(1'b0, 8'hF9,  7, 56'h2D303037430D0A, 2, 0, 1'b0);
    do_frame(1'b0, 8'h80,  7, 56'h2D313238430D0A, 1, 0, 1'b0);
    do_frame(1'b0, 8'd0,   7, 56'h2B303030430D0A, 4, 0, 1'b0);
    do_frame(1'b0, 8'd99,  7, 56'h2B303939430D0A, 1, 0, 1'b0);
    do_frame(1'b0, 8'd100, 7, 56'h2B313030430D0A, 1, 0, 1'b0);
    do_frame(1'b0, 8'd9,   7, 56'h2B303039430D0A, 1, 0, 1'b0);
    do_frame(1'b0, 8'd127, 7, 56'h2B313237430D0A, 1, 0, 1'b0);
    do_frame(1'b0, 8'd42,  7, 56'h2B303432430D0A, 2, 1, 1'b0);
    do_frame(1'b0, 8'd5,   7, 56'h2B303035430D0A, 1, 2, 1'b0);
    do_frame(1'b0, 8'd73,  7, 56'h2B303733430D0A, 3000, 0, 1'b0);

    // Stray done pulse while idle must not start anything.
    @(posedge clk); #1 tx_done_tick = 1'b1;
    @(posedge clk); #1 tx_done_tick = 1'b0;
    repeat (5) @(posedge clk);

    do_frame(1'b0, 8'd61, 7, 56'h2B303631430D0A, 2, 3, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (20) @(posedge clk);

    // Request in the first cycle after reset release.
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1; temp_valid = 1'b1; temp_value = 8'd88;
    do_frame(1'b0, 8'd88, 7, 56'h2B303838430D0A, 1, 0, 1'b1);

    do_frame(1'b1, 8'd127, 6, 56'h2B31323743_0A00, 2, 0, 1'b0);
    chk1("lf_no_drop", lf_drop, 1'b0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/temp_report_seq.md
TEMP_REPORT_SEQ -- requirements
Module: temp_report_seq

Interface
REQ-001 Parameter: UNIT_CHAR, default 8'h43 ('C'), ASCII unit character sent after the digits.
REQ-002 Parameter: EOL_CRLF, default 1; 1 = frame ends CR LF (7 bytes), 0 = frame ends LF only (6 bytes).
REQ-003 Port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: temp_valid  input  1  one-cycle strobe; temp_value is valid this cycle.
REQ-006 Port: temp_value  input  8  signed two's-complement temperature in degrees, range -128..127.
REQ-007 Port: tx_done_tick  input  1  one-cycle pulse from the UART transmitter at the end of a stop bit.
REQ-008 Port: data_byte  output  8  ASCII byte presented to the UART transmitter.
REQ-009 Port: tx_start  output  1  active-low transmit request to the UART transmitter.
REQ-010 Port: busy  output  1  high from the capture cycle until frame completion.
REQ-011 Port: frame_done_tick  output  1  one-cycle pulse when the last byte's tx_done_tick is received.
REQ-012 Port: drop_tick  output  1  one-cycle pulse when temp_valid arrives while busy.

Function
REQ-013 The block SHALL use a state machine with states IDLE, CONV, SEND and WAIT.
REQ-014 IDLE: on temp_valid, the block SHALL latch sign = temp_value[7] and magnitude = |temp_value| (9-bit, so -128 gives 128), clear the digit counters and byte index, and go to CONV.
REQ-015 CONV: the block SHALL apply one step per cycle, in this order:
- if the remainder >= 100: subtract 100 and increment hundreds;
- else if the remainder >= 10: subtract 10 and increment tens;
- else: units = remainder, then go to SEND.
REQ-016 CONV SHALL take at most 11 cycles for any input.
REQ-017 Frame byte order SHALL be:
- sign: 8'h2D ('-') if negative, else 8'h2B ('+');
- hundreds, tens and units as 8'h30 + digit, with leading zeros kept;
- UNIT_CHAR;
- 8'h0D (only if EOL_CRLF = 1);
- 8'h0A.
REQ-018 SEND: the block SHALL drive data_byte with the byte at the current index, drive tx_start low for exactly this one cycle, and go to WAIT.
REQ-019 WAIT: tx_start SHALL be high and data_byte SHALL hold unchanged until tx_done_tick, because the transmitter samples data_byte up to one bit-time after the request.
REQ-020 On tx_done_tick in WAIT with bytes remaining, the block SHALL increment the index and go to SEND, so the next tx_start low occurs exactly 1 cycle after tx_done_tick.
REQ-021 On tx_done_tick in WAIT for the last byte, the block SHALL pulse frame_done_tick in that same cycle and go to IDLE; busy SHALL deassert the following cycle.
REQ-022 busy SHALL be high in CONV, SEND and WAIT, and low in IDLE.
REQ-023 temp_valid received in any state other than IDLE SHALL be ignored, SHALL not alter the frame in progress, and SHALL pulse drop_tick in the same cycle.
REQ-024 tx_done_tick in IDLE, CONV or SEND SHALL be ignored.
REQ-025 tx_start SHALL never be low for two consecutive cycles.
REQ-026 temp_valid coincident with frame_done_tick SHALL be dropped, since the block is still in WAIT that cycle.

Reset
REQ-027 While reset is low, the block SHALL be in IDLE with the following output values:
- tx_start = 1;
- data_byte = 8'hFF;
- busy = 0;
- frame_done_tick = 0;
- drop_tick = 0;
- all counters and latches = 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately; no tx_start low SHALL follow until a new temp_valid after reset release.
REQ-029 After reset release, the block SHALL accept temp_valid in the very first cycle.

Verification
REQ-030 Input temp_value = 25, with a UART transmitter model returning tx_done_tick -> data_byte sequence 2B 30 32 35 43 0D 0A, 7 tx_start low pulses, one frame_done_tick.
REQ-031 Input temp_value = -7 -> 2D 30 30 37 43 0D 0A. Input temp_value = -128 -> 2D 31 32 38 43 0D 0A. Input temp_value = 0 -> 2B 30 30 30 43 0D 0A.
REQ-032 With EOL_CRLF = 0, input temp_value = 127 -> 2B 31 32 37 43 0A and frame_done_tick after the 6th tx_done_tick.
REQ-033 Apply temp_valid = 50 during WAIT of byte 3 -> drop_tick pulses once; the frame in progress completes unchanged with the original value.
REQ-034 Assert reset during WAIT of byte 2 -> tx_start = 1, busy = 0 and data_byte = 8'hFF immediately; no further tx_start until a new temp_valid.
REQ-035 Delay tx_done_tick by 3000 cycles -> data_byte stable for the whole interval and tx_start high throughout; check 1-cycle done-to-start spacing and at most 11 CONV cycles for inputs 99, 100, 128 and 9.
